// File: rtl/lp_filter_scheduler_if.sv
// Sample/result bus for lp_filter_scheduler.
//   in_valid/in_value/clear : per-channel samples and synchronous clears (master -> slave)
//   in_ready                : per-channel accept flags, combinational (slave -> master)
//   out_valid/out_channel/out_value : registered filtered result stream (slave -> master)
interface lp_filter_scheduler_if #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned IN_DATA_BITS  = 30,
    parameter int unsigned OUT_DATA_BITS = 33,
    parameter int unsigned CH_BITS       = 2
);
    logic [CHANNELS-1:0]              in_valid;
    logic [CHANNELS*IN_DATA_BITS-1:0] in_value;
    logic [CHANNELS-1:0]              in_ready;
    logic [CHANNELS-1:0]              clear;
    logic                             out_valid;
    logic [CH_BITS-1:0]               out_channel;
    logic [OUT_DATA_BITS-1:0]         out_value;

    modport master (
        output in_valid, in_value, clear,
        input  in_ready, out_valid, out_channel, out_value
    );

    modport slave (
        input  in_valid, in_value, clear,
        output in_ready, out_valid, out_channel, out_value
    );
endinterface

// File: rtl/lp_filter_scheduler.sv
// Time-shared first-order low-pass filter: CHANNELS inputs, one shared update.
// Each channel has a one-entry holding buffer; a round-robin arbiter (stage A)
// feeds one sample per cycle into the update stage (stage B), which computes
// acc += sample - acc>>SHIFT_BITS and emits the top OUT_DATA_BITS of acc.
// Ports:
//   clk_i   : clock, all state on rising edge
//   rst_n_i : asynchronous active-low reset
//   ce_i    : clock enable, 0 freezes all state and drops in_ready
//   bus     : sample/clear/result bus (slave side)
module lp_filter_scheduler #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned IN_DATA_BITS  = 30,
    parameter int unsigned SHIFT_BITS    = 6,
    parameter int unsigned OUT_DATA_BITS = 33,
    parameter int unsigned CH_BITS       = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  ce_i,
    lp_filter_scheduler_if.slave  bus
);

    localparam int unsigned INT_BITS = IN_DATA_BITS + SHIFT_BITS;

    logic [CHANNELS-1:0]     pending_q, pending_d;
    logic [IN_DATA_BITS-1:0] hold_q [CHANNELS];
    logic [IN_DATA_BITS-1:0] hold_d [CHANNELS];
    logic [INT_BITS-1:0]     acc_q  [CHANNELS];
    logic [INT_BITS-1:0]     acc_d  [CHANNELS];
    logic                    b_valid_q, b_valid_d;
    logic [CH_BITS-1:0]      b_ch_q, b_ch_d;
    logic [IN_DATA_BITS-1:0] b_sample_q, b_sample_d;
    logic [CH_BITS-1:0]      last_grant_q, last_grant_d;
    logic                    out_valid_q, out_valid_d;
    logic [CH_BITS-1:0]      out_ch_q, out_ch_d;
    logic [OUT_DATA_BITS-1:0] out_value_q, out_value_d;

    logic [CHANNELS-1:0]     in_ready_c;
    logic [CHANNELS-1:0]     accept_c;
    logic [CHANNELS-1:0]     eligible_c;
    logic                    grant_valid_c;
    logic [CH_BITS-1:0]      grant_ch_c;
    logic [INT_BITS-1:0]     acc_cur_c;
    logic signed [INT_BITS:0] diff_c;
    logic [INT_BITS-1:0]     acc_new_c;

    // Handshake: a channel is ready when enabled, its buffer is empty and it is not being cleared
    assign in_ready_c   = {CHANNELS{ce_i}} & ~pending_q & ~bus.clear;
    assign accept_c     = bus.in_valid & in_ready_c;
    assign bus.in_ready = in_ready_c;

    // A channel being cleared this edge is skipped by the arbiter
    assign eligible_c = pending_q & ~bus.clear;

    // Round-robin: first eligible channel above last_grant, else lowest eligible (wrap-around)
    always_comb begin
        grant_valid_c = 1'b0;
        grant_ch_c    = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (!grant_valid_c && eligible_c[c] && (CH_BITS'(c) > last_grant_q)) begin
                grant_valid_c = 1'b1;
                grant_ch_c    = CH_BITS'(c);
            end
        end
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (!grant_valid_c && eligible_c[c]) begin
                grant_valid_c = 1'b1;
                grant_ch_c    = CH_BITS'(c);
            end
        end
    end

    // Filter update: diff is signed with one extra bit, the sum wraps to INT_BITS
    always_comb begin
        acc_cur_c = acc_q[b_ch_q];
        diff_c    = $signed({{(SHIFT_BITS + 1){1'b0}}, b_sample_q})
                  - $signed({{(SHIFT_BITS + 1){1'b0}}, acc_cur_c[INT_BITS-1:SHIFT_BITS]});
        acc_new_c = INT_BITS'($unsigned(diff_c) + {1'b0, acc_cur_c});
    end

    // Next-state: accept, stage B update, stage A grant, then clears override
    always_comb begin
        pending_d    = pending_q;
        hold_d       = hold_q;
        acc_d        = acc_q;
        b_valid_d    = b_valid_q;
        b_ch_d       = b_ch_q;
        b_sample_d   = b_sample_q;
        last_grant_d = last_grant_q;
        out_valid_d  = out_valid_q;
        out_ch_d     = out_ch_q;
        out_value_d  = out_value_q;

        if (ce_i) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (accept_c[c]) begin
                    pending_d[c] = 1'b1;
                    hold_d[c]    = bus.in_value[c*IN_DATA_BITS +: IN_DATA_BITS];
                end
            end

            out_valid_d = 1'b0;
            if (b_valid_q && !bus.clear[b_ch_q]) begin
                acc_d[b_ch_q] = acc_new_c;
                out_valid_d   = 1'b1;
                out_ch_d      = b_ch_q;
                out_value_d   = acc_new_c[INT_BITS-1 -: OUT_DATA_BITS];
            end

            b_valid_d = grant_valid_c;
            if (grant_valid_c) begin
                pending_d[grant_ch_c] = 1'b0;
                b_ch_d                = grant_ch_c;
                b_sample_d            = hold_q[grant_ch_c];
                last_grant_d          = grant_ch_c;
            end

            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (bus.clear[c]) begin
                    acc_d[c]     = '0;
                    pending_d[c] = 1'b0;
                end
            end
        end
    end

    // State registers; last_grant resets to the top channel so channel 0 wins first
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pending_q    <= '0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                hold_q[c] <= '0;
                acc_q[c]  <= '0;
            end
            b_valid_q    <= 1'b0;
            b_ch_q       <= '0;
            b_sample_q   <= '0;
            last_grant_q <= CH_BITS'(CHANNELS - 1);
            out_valid_q  <= 1'b0;
            out_ch_q     <= '0;
            out_value_q  <= '0;
        end else begin
            pending_q    <= pending_d;
            hold_q       <= hold_d;
            acc_q        <= acc_d;
            b_valid_q    <= b_valid_d;
            b_ch_q       <= b_ch_d;
            b_sample_q   <= b_sample_d;
            last_grant_q <= last_grant_d;
            out_valid_q  <= out_valid_d;
            out_ch_q     <= out_ch_d;
            out_value_q  <= out_value_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_channel = out_ch_q;
    assign bus.out_value   = out_value_q;

endmodule

// File: tb/tb_lp_filter_scheduler.sv
// Self-checking bench for lp_filter_scheduler: directed scenarios plus a
// randomized run scored against a per-channel filter model.
module tb_lp_filter_scheduler;

    localparam int unsigned CH = 4;
    localparam int unsigned IW = 30;
    localparam int unsigned SH = 6;
    localparam int unsigned OW = 33;
    localparam int unsigned CW = 2;
    localparam int unsigned AW = IW + SH;

    logic clk = 1'b0;
    logic rst_n;
    logic ce;

    always #5 clk = ~clk;

    lp_filter_scheduler_if #(.CHANNELS(CH), .IN_DATA_BITS(IW), .OUT_DATA_BITS(OW), .CH_BITS(CW)) bus ();

    lp_filter_scheduler #(
        .CHANNELS(CH), .IN_DATA_BITS(IW), .SHIFT_BITS(SH), .OUT_DATA_BITS(OW), .CH_BITS(CW)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .ce_i    (ce),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [IW-1:0] mq [CH][$];
    logic [AW-1:0] macc [CH];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = '0;
        bus.clear    = '0;
    endtask

    task automatic drive(input int c, input logic [IW-1:0] v);
        bus.in_valid[c]        = 1'b1;
        bus.in_value[c*IW +: IW] = v;
    endtask

    task automatic do_reset();
        idle();
        ce    = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0d exp 0", bus.out_valid); end
        checks++; if (bus.out_value !== 33'd0) begin errors++; $display("FAIL reset_out_value got %0d exp 0", bus.out_value); end
        checks++; if (bus.out_channel !== 2'd0) begin errors++; $display("FAIL reset_out_channel got %0d exp 0", bus.out_channel); end
        checks++; if (bus.in_ready !== 4'hF) begin errors++; $display("FAIL reset_in_ready got %h exp f", bus.in_ready); end
        ce = 1'b0; #1;
        checks++; if (bus.in_ready !== 4'h0) begin errors++; $display("FAIL ce_low_in_ready got %h exp 0", bus.in_ready); end
        ce = 1'b1; bus.clear = 4'b0101; #1;
        checks++; if (bus.in_ready !== 4'b1010) begin errors++; $display("FAIL clear_in_ready got %h exp a", bus.in_ready); end
        idle(); #1;
    endtask

    task automatic test_step();
        do_reset();
        drive(0, 30'd1000);
        tick();
        idle();
        checks++; if (bus.in_ready[0] !== 1'b0) begin errors++; $display("FAIL step_ready_pending got %0d exp 0", bus.in_ready[0]); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL step_k0_valid got %0d exp 0", bus.out_valid); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL step_k1_valid got %0d exp 0", bus.out_valid); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_channel !== 2'd0 || bus.out_value !== 33'd125) begin
            errors++; $display("FAIL step_first got v=%0d ch=%0d val=%0d exp v=1 ch=0 val=125", bus.out_valid, bus.out_channel, bus.out_value); end
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.out_value !== 33'd125) begin
            errors++; $display("FAIL step_hold got v=%0d val=%0d exp v=0 val=125", bus.out_valid, bus.out_value); end
        drive(0, 30'd1000);
        tick();
        idle();
        tick();
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_value !== 33'd248) begin
            errors++; $display("FAIL step_second got v=%0d val=%0d exp v=1 val=248", bus.out_valid, bus.out_value); end
    endtask

    // Runs right after test_step so acc[0] is non-zero going in
    task automatic test_clear();
        drive(0, 30'd1000);
        tick();
        idle();
        tick();
        bus.clear[0] = 1'b1;
        #1;
        checks++; if (bus.in_ready[0] !== 1'b0) begin errors++; $display("FAIL clear_ready got %0d exp 0", bus.in_ready[0]); end
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.out_value !== 33'd248) begin
            errors++; $display("FAIL clear_discard got v=%0d val=%0d exp v=0 val=248", bus.out_valid, bus.out_value); end
        idle();
        drive(0, 30'd1000);
        tick();
        idle();
        tick();
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_value !== 33'd125) begin
            errors++; $display("FAIL clear_restart got v=%0d val=%0d exp v=1 val=125", bus.out_valid, bus.out_value); end
    endtask

    task automatic test_all_four();
        do_reset();
        for (int c = 0; c < int'(CH); c++) drive(c, IW'(1000 * (c + 1)));
        tick();
        idle();
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL all4_pre got %0d exp 0", bus.out_valid); end
        for (int c = 0; c < int'(CH); c++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_channel !== CW'(c) || bus.out_value !== OW'(125 * (c + 1))) begin
                errors++; $display("FAIL all4_out%0d got v=%0d ch=%0d val=%0d exp v=1 ch=%0d val=%0d",
                                   c, bus.out_valid, bus.out_channel, bus.out_value, c, 125 * (c + 1)); end
        end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL all4_post got %0d exp 0", bus.out_valid); end
    endtask

    task automatic test_fairness();
        do_reset();
        drive(1, 30'd500);
        drive(2, 30'd700);
        tick();
        tick();
        for (int n = 0; n < 10; n++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_channel !== ((n % 2 == 0) ? 2'd1 : 2'd2)) begin
                errors++; $display("FAIL fair_%0d got v=%0d ch=%0d exp v=1 ch=%0d",
                                   n, bus.out_valid, bus.out_channel, (n % 2 == 0) ? 1 : 2); end
        end
        idle();
        repeat (4) tick();
    endtask

    task automatic test_ce_freeze();
        do_reset();
        for (int c = 0; c < int'(CH); c++) drive(c, IW'(1000 * (c + 1)));
        tick();
        idle();
        tick();
        tick();
        ce = 1'b0;
        drive(0, 30'd9999);
        #1;
        checks++; if (bus.in_ready !== 4'h0) begin errors++; $display("FAIL ce_ready got %h exp 0", bus.in_ready); end
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_channel !== 2'd0 || bus.out_value !== 33'd125) begin
                errors++; $display("FAIL ce_frozen_%0d got v=%0d ch=%0d val=%0d exp v=1 ch=0 val=125",
                                   n, bus.out_valid, bus.out_channel, bus.out_value); end
        end
        idle();
        ce = 1'b1;
        for (int c = 1; c < int'(CH); c++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_channel !== CW'(c) || bus.out_value !== OW'(125 * (c + 1))) begin
                errors++; $display("FAIL ce_resume_%0d got v=%0d ch=%0d val=%0d exp v=1 ch=%0d val=%0d",
                                   c, bus.out_valid, bus.out_channel, bus.out_value, c, 125 * (c + 1)); end
        end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ce_no_inject got %0d exp 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < int'(CH); c++) drive(c, IW'(1000 * (c + 1)));
        tick();
        idle();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_value !== 33'd0) begin
            errors++; $display("FAIL rstmid_async got v=%0d val=%0d exp v=0 val=0", bus.out_valid, bus.out_value); end
        #1;
        rst_n = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 4'hF) begin errors++; $display("FAIL rstmid_ready got %h exp f", bus.in_ready); end
        for (int n = 0; n < 8; n++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_quiet_%0d got %0d exp 0", n, bus.out_valid); end
        end
    endtask

    task automatic test_random();
        logic [CH-1:0] acc_mask;
        logic          ce_edge;
        logic [IW-1:0] s;
        logic [OW-1:0] exp_v;
        int            ch;
        int            left;
        do_reset();
        for (int c = 0; c < int'(CH); c++) begin
            mq[c].delete();
            macc[c] = '0;
        end
        for (int cyc = 0; cyc < 616; cyc++) begin
            if (cyc < 600) begin
                ce = ($urandom_range(0, 9) != 0);
                for (int c = 0; c < int'(CH); c++) begin
                    bus.in_valid[c]          = 1'($urandom_range(0, 1));
                    bus.in_value[c*IW +: IW] = IW'($urandom);
                end
            end else begin
                ce = 1'b1;
                idle();
            end
            #1;
            if (!ce) begin
                checks++; if (bus.in_ready !== 4'h0) begin errors++; $display("FAIL rand_ce_ready cyc %0d got %h exp 0", cyc, bus.in_ready); end
            end
            acc_mask = bus.in_valid & bus.in_ready;
            ce_edge  = ce;
            for (int c = 0; c < int'(CH); c++)
                if (acc_mask[c]) mq[c].push_back(bus.in_value[c*IW +: IW]);
            tick();
            if (ce_edge && bus.out_valid === 1'b1) begin
                ch = int'(bus.out_channel);
                checks++;
                if (mq[ch].size() == 0) begin
                    errors++; $display("FAIL rand_spurious cyc %0d got ch=%0d exp no output for it", cyc, ch);
                end else begin
                    s        = mq[ch].pop_front();
                    macc[ch] = macc[ch] + AW'(s) - (macc[ch] >> SH);
                    exp_v    = OW'(macc[ch] >> (AW - OW));
                    if (bus.out_value !== exp_v) begin
                        errors++; $display("FAIL rand_value cyc %0d ch=%0d got %0d exp %0d", cyc, ch, bus.out_value, exp_v);
                    end
                end
            end
        end
        left = 0;
        for (int c = 0; c < int'(CH); c++) left += mq[c].size();
        checks++; if (left != 0) begin errors++; $display("FAIL rand_drain got %0d unserved samples exp 0", left); end
    endtask

    initial begin
        rst_n        = 1'b0;
        ce           = 1'b1;
        bus.in_valid = '0;
        bus.in_value = '0;
        bus.clear    = '0;
        test_reset();
        test_step();
        test_clear();
        test_all_four();
        test_fairness();
        test_ce_freeze();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
